spi_arbiter: RTL and testbench

Shares one soft-SPI byte engine among N requesters and sequences each transaction: it arbitrates round-robin, drives that requester's active-low chip select, and enforces CS setup and hold gaps. It issues byte reads and writes to the engine over a level req/ack 4-phase handshake. It sits between the CPU-side SPI clients (SD card, flash, peripheral) and the single shift engine that drives MOSI/SCLK/MISO.

---
 rtl/spi_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_spi_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_arbiter.sv
// Round-robin arbiter sequencing N SPI clients onto one byte engine with CS setup/hold gaps.
// Optional WAIT_CMD idle timeout is built when SPI_ARB_TIMEOUT_EN is defined.
module spi_arbiter #(
   parameter int unsigned N        = 3,
   parameter int unsigned CS_SETUP = 2,
   parameter int unsigned CS_HOLD  = 2,
   parameter int unsigned TIMEOUT  = 1023
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [N-1:0]   req,
   input  logic [N-1:0]   cmd_valid,
   input  logic [N-1:0]   cmd_rw,
   input  logic [N-1:0]   cmd_last,
   input  logic [8*N-1:0] cmd_wdata,
   output logic [N-1:0]   cmd_ready,
   output logic [N-1:0]   rsp_valid,
   output logic [7:0]     rsp_rdata,
   output logic [N-1:0]   gnt,
   output logic [N-1:0]   CS,
   output logic [N-1:0]   timeout,
   output logic           eng_rd_req,
   output logic           eng_wr_req,
   output logic [7:0]     eng_wdata,
   input  logic           eng_ack,
   input  logic [7:0]     eng_rdata
);
   localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned CW = 16;

   if (N < 1 || N > 8 || CS_SETUP < 1 || CS_HOLD < 1 || TIMEOUT < 1) begin : g_bad_param
      $error("spi_arbiter: parameter out of range");
   end

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_WAIT_CMD, S_ISSUE, S_RELEASE, S_HOLD
   } state_t;

   state_t        state_q;
   logic [PW-1:0] ptr_q;
   logic [N-1:0]  gnt_q;
   logic [N-1:0]  cs_q;
   logic [N-1:0]  cmd_ready_q;
   logic [N-1:0]  rsp_valid_q;
   logic [7:0]    rsp_rdata_q;
   logic          eng_rd_q;
   logic          eng_wr_q;
   logic [7:0]    eng_wdata_q;
   logic          rw_q;
   logic          last_q;
   logic [CW-1:0] cnt_q;

   logic [PW-1:0] pick_c;
   logic          found_c;
   logic [PW:0]   idx_c;
   logic [7:0]    wbyte_c [N];

   // First requester after ptr, wrapping modulo N.
   always_comb begin
      pick_c  = '0;
      found_c = 1'b0;
      idx_c   = '0;
      for (int unsigned i = 1; i <= N; i++) begin
         idx_c = (PW+1)'(ptr_q) + (PW+1)'(i);
         if (idx_c >= (PW+1)'(N)) idx_c = idx_c - (PW+1)'(N);
         if (!found_c && req[idx_c[PW-1:0]]) begin
            pick_c  = idx_c[PW-1:0];
            found_c = 1'b1;
         end
      end
   end

   always_comb begin
      for (int unsigned i = 0; i < N; i++) wbyte_c[i] = cmd_wdata[8*i +: 8];
   end

`ifdef SPI_ARB_TIMEOUT_EN
   logic [CW-1:0] tmo_q;
   logic [N-1:0]  timeout_q;
   logic          tmo_hit_c;

   assign tmo_hit_c = (tmo_q == CW'(TIMEOUT - 1));

   // Idle counter: runs only while the owner sits in WAIT_CMD without a command.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) tmo_q <= '0;
      else if (state_q == S_WAIT_CMD && !cmd_valid[ptr_q]) tmo_q <= tmo_q + CW'(1);
      else tmo_q <= '0;
   end
   assign timeout = timeout_q;
`else
   assign timeout = '0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         ptr_q       <= PW'(N - 1);
         gnt_q       <= '0;
         cs_q        <= '1;
         cmd_ready_q <= '0;
         rsp_valid_q <= '0;
         rsp_rdata_q <= '0;
         eng_rd_q    <= 1'b0;
         eng_wr_q    <= 1'b0;
         eng_wdata_q <= '0;
         rw_q        <= 1'b0;
         last_q      <= 1'b0;
         cnt_q       <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
         timeout_q   <= '0;
`endif
      end else begin
         rsp_valid_q <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
         timeout_q   <= '0;
`endif
         case (state_q)
            S_IDLE: begin
               if (found_c) begin
                  gnt_q   <= N'(1) << pick_c;
                  cs_q    <= ~(N'(1) << pick_c);
                  ptr_q   <= pick_c;
                  cnt_q   <= '0;
                  state_q <= S_SETUP;
               end
            end
            S_SETUP: begin
               if (cnt_q == CW'(CS_SETUP - 1)) begin
                  cmd_ready_q <= gnt_q;
                  state_q     <= S_WAIT_CMD;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            S_WAIT_CMD: begin
               if (cmd_valid[ptr_q]) begin
                  rw_q        <= cmd_rw[ptr_q];
                  last_q      <= cmd_last[ptr_q];
                  eng_wdata_q <= wbyte_c[ptr_q];
                  eng_rd_q    <= cmd_rw[ptr_q];
                  eng_wr_q    <= ~cmd_rw[ptr_q];
                  cmd_ready_q <= '0;
                  state_q     <= S_ISSUE;
               end else if (!req[ptr_q]) begin
                  cmd_ready_q <= '0;
                  gnt_q       <= '0;
                  cs_q        <= '1;
                  cnt_q       <= '0;
                  state_q     <= S_HOLD;
               end
`ifdef SPI_ARB_TIMEOUT_EN
               else if (tmo_hit_c) begin
                  timeout_q   <= gnt_q;
                  cmd_ready_q <= '0;
                  gnt_q       <= '0;
                  cs_q        <= '1;
                  cnt_q       <= '0;
                  state_q     <= S_HOLD;
               end
`endif
            end
            S_ISSUE: begin
               if (eng_ack) begin
                  if (rw_q) rsp_rdata_q <= eng_rdata;
                  eng_rd_q <= 1'b0;
                  eng_wr_q <= 1'b0;
                  state_q  <= S_RELEASE;
               end
            end
            S_RELEASE: begin
               // A dropped req is only honoured once the byte has fully completed.
               if (!eng_ack) begin
                  rsp_valid_q <= gnt_q;
                  if (last_q || !req[ptr_q]) begin
                     gnt_q   <= '0;
                     cs_q    <= '1;
                     cnt_q   <= '0;
                     state_q <= S_HOLD;
                  end else begin
                     cmd_ready_q <= gnt_q;
                     state_q     <= S_WAIT_CMD;
                  end
               end
            end
            S_HOLD: begin
               if (cnt_q == CW'(CS_HOLD - 1)) state_q <= S_IDLE;
               else cnt_q <= cnt_q + CW'(1);
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign gnt        = gnt_q;
   assign CS         = cs_q;
   assign cmd_ready  = cmd_ready_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_rdata  = rsp_rdata_q;
   assign eng_rd_req = eng_rd_q;
   assign eng_wr_req = eng_wr_q;
   assign eng_wdata  = eng_wdata_q;
endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter: vector table of byte transactions plus hand-written corner sequences.
module tb_spi_arbiter;
   localparam int unsigned N = 3;
   localparam int unsigned CS_SETUP = 2;
   localparam int unsigned CS_HOLD = 2;
`ifdef SPI_ARB_TIMEOUT_EN
   localparam int unsigned TMO = 8;
`else
   localparam int unsigned TMO = 1023;
`endif
   localparam logic [N-1:0] ALL1 = '1;

   logic           clk, reset;
   logic [N-1:0]   req, cmd_valid, cmd_rw, cmd_last;
   logic [8*N-1:0] cmd_wdata;
   logic [N-1:0]   cmd_ready, rsp_valid, gnt, CS, timeout;
   logic [7:0]     rsp_rdata, eng_wdata, eng_rdata;
   logic           eng_rd_req, eng_wr_req, eng_ack;

   spi_arbiter #(.N(N), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset), .req(req), .cmd_valid(cmd_valid), .cmd_rw(cmd_rw),
      .cmd_last(cmd_last), .cmd_wdata(cmd_wdata), .cmd_ready(cmd_ready),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .gnt(gnt), .CS(CS),
      .timeout(timeout), .eng_rd_req(eng_rd_req), .eng_wr_req(eng_wr_req),
      .eng_wdata(eng_wdata), .eng_ack(eng_ack), .eng_rdata(eng_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cs_multi = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Engine model: acks after eng_dly visible cycles, checks handshake timing.
   logic [7:0] eng_data;
   int         eng_dly;
   int         eng_cnt;
   bit         rsp_chk;

   always @(negedge clk or posedge reset) begin
      if (reset) begin
         eng_ack = 1'b0;
         eng_rdata = 8'h00;
         eng_cnt = 0;
         rsp_chk = 1'b0;
      end else begin
         if (rsp_chk) begin
            chk("rsp_after_ack_low", 32'(|rsp_valid), 32'd1);
            rsp_chk = 1'b0;
         end
         if (eng_rd_req || eng_wr_req)
            chk("eng_req_exclusive", 32'(eng_rd_req & eng_wr_req), 32'd0);
         if (eng_ack) begin
            chk("req_drop_after_ack", 32'(eng_rd_req | eng_wr_req), 32'd0);
            eng_ack = 1'b0;
            rsp_chk = 1'b1;
         end else if (eng_rd_req || eng_wr_req) begin
            if (eng_cnt >= eng_dly) begin
               eng_ack = 1'b1;
               eng_rdata = eng_data;
               eng_cnt = 0;
            end else begin
               eng_cnt++;
            end
         end
      end
   end

   always @(negedge clk) if (!reset && $countones(~CS) > 1) cs_multi++;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   typedef struct {
      logic [N-1:0] req_mask;
      int           rq;
      logic         rw;
      logic [7:0]   wdata;
      logic         last;
      logic [7:0]   edata;
      int           dly;
      logic [N-1:0] exp_gnt;
      logic [7:0]   exp_rdata;
      logic [N-1:0] req_after;
   } vec_t;

   vec_t tbl [7];

   task automatic wait_ready(input int rq);
      for (int k = 0; k < 60 && !cmd_ready[rq]; k++) tick();
      if (!cmd_ready[rq]) chk("cmd_ready_wait", 32'(cmd_ready[rq]), 32'd1);
   endtask

   task automatic wait_rsp(input int rq, input logic [N-1:0] cs_exp, output int cs_bad);
      cs_bad = 0;
      for (int k = 0; k < 200 && !rsp_valid[rq]; k++) begin
         if (CS !== cs_exp) cs_bad++;
         tick();
      end
      if (!rsp_valid[rq]) chk("rsp_wait", 32'(rsp_valid[rq]), 32'd1);
   endtask

   task automatic drive_cmd(input int rq, input logic rw, input logic [7:0] wd, input logic last);
      cmd_valid = '0; cmd_rw = '0; cmd_last = '0; cmd_wdata = '0;
      cmd_valid[rq] = 1'b1;
      cmd_rw[rq] = rw;
      cmd_last[rq] = last;
      cmd_wdata[8*rq +: 8] = wd;
   endtask

   task automatic run_byte(input vec_t v);
      logic [N-1:0] cs_low, cs_rsp;
      int cs_bad;
      cs_low = ~v.exp_gnt;
      cs_rsp = v.last ? ALL1 : cs_low;
      req = v.req_mask;
      wait_ready(v.rq);
      chk("gnt", 32'(gnt), 32'(v.exp_gnt));
      chk("cs_owner", 32'(CS), 32'(cs_low));
      chk("cmd_ready_onehot", 32'(cmd_ready), 32'(v.exp_gnt));
      eng_data = v.edata;
      eng_dly = v.dly;
      drive_cmd(v.rq, v.rw, v.wdata, v.last);
      tick();
      cmd_valid = '0;
      chk("eng_rd_req", 32'(eng_rd_req), 32'(v.rw));
      chk("eng_wr_req", 32'(eng_wr_req), 32'(!v.rw));
      chk("eng_wdata", 32'(eng_wdata), 32'(v.wdata));
      wait_rsp(v.rq, cs_low, cs_bad);
      chk("cs_during_byte", 32'(cs_bad), 32'd0);
      chk("rsp_valid", 32'(rsp_valid), 32'(v.exp_gnt));
      chk("rsp_rdata", 32'(rsp_rdata), 32'(v.exp_rdata));
      chk("cs_at_rsp", 32'(CS), 32'(cs_rsp));
      req = v.req_after;
      tick();
      chk("rsp_single_pulse", 32'(rsp_valid), 32'd0);
   endtask

   initial begin
      int gap, cs_bad, bad_cyc;
      tbl[0] = '{3'b010, 1, 1'b1, 8'h00, 1'b0, 8'h11, 3, 3'b010, 8'h11, 3'b010};
      tbl[1] = '{3'b010, 1, 1'b1, 8'h00, 1'b0, 8'h22, 0, 3'b010, 8'h22, 3'b010};
      tbl[2] = '{3'b010, 1, 1'b1, 8'h00, 1'b1, 8'h33, 5, 3'b010, 8'h33, 3'b000};
      tbl[3] = '{3'b111, 0, 1'b0, 8'h01, 1'b1, 8'hEE, 2, 3'b001, 8'h5A, 3'b111};
      tbl[4] = '{3'b111, 1, 1'b0, 8'h02, 1'b1, 8'hEE, 1, 3'b010, 8'h5A, 3'b111};
      tbl[5] = '{3'b111, 2, 1'b0, 8'h03, 1'b1, 8'hEE, 0, 3'b100, 8'h5A, 3'b111};
      tbl[6] = '{3'b111, 0, 1'b0, 8'h04, 1'b1, 8'hEE, 2, 3'b001, 8'h5A, 3'b000};

      reset = 1'b1; req = '0; cmd_valid = '0; cmd_rw = '0; cmd_last = '0; cmd_wdata = '0;
      eng_data = 8'h00; eng_dly = 0;
      repeat (3) tick();
      chk("rst_cs", 32'(CS), 32'(ALL1));
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_timeout", 32'(timeout), 32'd0);
      chk("rst_eng_req", 32'({eng_rd_req, eng_wr_req}), 32'd0);
      chk("rst_rdata", 32'(rsp_rdata), 32'd0);
      chk("rst_wdata", 32'(eng_wdata), 32'd0);
      reset = 1'b0;
      tick();

      // Single write with exact grant/setup/issue latencies and the CS hold gap.
      req = 3'b001;
      tick();
      chk("w_gnt_latency", 32'(gnt), 32'd1);
      chk("w_cs_latency", 32'(CS), 32'(3'b110));
      chk("w_ready_early0", 32'(cmd_ready), 32'd0);
      tick();
      chk("w_ready_early1", 32'(cmd_ready), 32'd0);
      tick();
      chk("w_ready_setup", 32'(cmd_ready), 32'd1);
      eng_dly = 20;
      drive_cmd(0, 1'b0, 8'hA5, 1'b1);
      tick();
      cmd_valid = '0;
      chk("w_eng_wr_req", 32'(eng_wr_req), 32'd1);
      chk("w_eng_wdata", 32'(eng_wdata), 32'hA5);
      chk("w_ready_drop", 32'(cmd_ready), 32'd0);
      wait_rsp(0, 3'b110, cs_bad);
      chk("w_cs_during", 32'(cs_bad), 32'd0);
      chk("w_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("w_rdata_kept", 32'(rsp_rdata), 32'd0);
      gap = 0;
      while (CS == ALL1 && gap < 20) begin
         gap++;
         tick();
      end
      chk("w_hold_gap", 32'(gap), 32'(CS_HOLD + 1));
      req = '0;
      repeat (10) tick();
      chk("w_release_cs", 32'(CS), 32'(ALL1));
      chk("w_release_gnt", 32'(gnt), 32'd0);

      // Read burst on requester 1.
      for (int i = 0; i < 3; i++) run_byte(tbl[i]);

      // Requester 2 drops req while its byte is in flight.
      req = 3'b100;
      wait_ready(2);
      chk("d_gnt", 32'(gnt), 32'(3'b100));
      eng_data = 8'h5A; eng_dly = 4;
      drive_cmd(2, 1'b1, 8'h00, 1'b0);
      tick();
      cmd_valid = '0;
      chk("d_eng_rd_req", 32'(eng_rd_req), 32'd1);
      req = '0;
      wait_rsp(2, 3'b011, cs_bad);
      chk("d_cs_during", 32'(cs_bad), 32'd0);
      chk("d_rsp_valid", 32'(rsp_valid), 32'(3'b100));
      chk("d_rsp_rdata", 32'(rsp_rdata), 32'h5A);
      chk("d_cs_high", 32'(CS), 32'(ALL1));
      chk("d_gnt_clear", 32'(gnt), 32'd0);
      tick();

      // Round-robin with all three requesting.
      for (int i = 3; i < 7; i++) run_byte(tbl[i]);

      // Asynchronous reset in the middle of an engine byte.
      req = 3'b010;
      wait_ready(1);
      eng_dly = 50;
      drive_cmd(1, 1'b0, 8'h77, 1'b1);
      tick();
      cmd_valid = '0;
      tick();
      chk("r_in_issue", 32'(eng_wr_req), 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("r_cs_async", 32'(CS), 32'(ALL1));
      chk("r_eng_req_async", 32'({eng_rd_req, eng_wr_req}), 32'd0);
      tick();
      tick();
      reset = 1'b0;
      req = 3'b011;
      tick();
      chk("r_first_gnt", 32'(gnt), 32'd1);

      // Owner idles in WAIT_CMD.
      wait_ready(0);
`ifdef SPI_ARB_TIMEOUT_EN
      repeat (7) tick();
      chk("t_no_early", 32'(timeout), 32'd0);
      tick();
      chk("t_pulse", 32'(timeout), 32'd1);
      chk("t_cs_high", 32'(CS), 32'(ALL1));
      tick();
      chk("t_pulse_end", 32'(timeout), 32'd0);
`else
      bad_cyc = 0;
      for (int k = 0; k < 60; k++) begin
         if (CS !== 3'b110 || timeout !== '0) bad_cyc++;
         tick();
      end
      chk("t_wait_forever", 32'(bad_cyc), 32'd0);
      chk("t_cs_still_low", 32'(CS), 32'(3'b110));
`endif
      req = '0;
      repeat (12) tick();
      chk("end_idle_cs", 32'(CS), 32'(ALL1));
      chk("cs_one_hot_low", 32'(cs_multi), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
